// File: rtl/mux_scan_seq.sv
// mux_scan_seq: walks the 4:1 mux selects through channels 0..3, holds each
// channel for DWELL cycles, samples SAIDA at the end of each dwell window and
// publishes the four samples as one frame with a single-cycle VALIDO pulse.
module mux_scan_seq #(
    parameter int unsigned DWELL = 2,
    parameter int unsigned QW    = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INICIO,
    input  logic          CONTINUO,
    input  logic          ABORTAR,
    input  logic          SAIDA,
    output logic          A,
    output logic          B,
    output logic [3:0]    DADOS,
    output logic          VALIDO,
    output logic          OCUPADO,
    output logic [QW-1:0] QUADROS
);

    // Dwell counter only ever has to reach DWELL-1; keep at least one bit.
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [1:0]    IDX_LAST = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      sh_q, sh_d;
    logic [3:0]      dados_q, dados_d;
    logic            valido_q, valido_d;
    logic            ocupado_q, ocupado_d;
    logic [QW-1:0]   quadros_q, quadros_d;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            sh_q      <= 3'd0;
            dados_q   <= 4'd0;
            valido_q  <= 1'b0;
            ocupado_q <= 1'b0;
            quadros_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            dados_q   <= dados_d;
            valido_q  <= valido_d;
            ocupado_q <= ocupado_d;
            quadros_q <= quadros_d;
        end
    end

    // Next-state logic: abort beats frame completion, which beats a new start.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        dados_d   = dados_q;
        valido_d  = 1'b0;
        ocupado_d = ocupado_q;
        quadros_d = quadros_q;

        case (state_q)
            IDLE: begin
                if (INICIO && !ABORTAR) begin
                    state_d   = SCAN;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                end
            end
            SCAN: begin
                if (ABORTAR) begin
                    state_d   = IDLE;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    sh_d      = 3'd0;
                    ocupado_d = 1'b0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (idx_q != IDX_LAST) begin
                    sh_d[idx_q] = SAIDA;
                    idx_d       = idx_q + 2'd1;
                    cnt_d       = '0;
                end else begin
                    dados_d   = {SAIDA, sh_q};
                    valido_d  = 1'b1;
                    quadros_d = quadros_q + QW'(1);
                    cnt_d     = '0;
                    idx_d     = 2'd0;
                    if (!CONTINUO) begin
                        state_d   = IDLE;
                        ocupado_d = 1'b0;
                    end
                end
            end
        endcase
    end

    // Selects come straight from the registered channel index (0 while idle).
    assign A       = idx_q[1];
    assign B       = idx_q[0];
    assign DADOS   = dados_q;
    assign VALIDO  = valido_q;
    assign OCUPADO = ocupado_q;
    assign QUADROS = quadros_q;

endmodule

// File: doc/mux_scan_seq.md
Name: mux_scan_seq

Overview:
- Sequencer that sits directly upstream and downstream of the 4:1 mux (X0..X3 → SAIDA, selects A/B).
- Drives the A/B select lines through channels 0..3 and holds each channel for a programmable dwell so the mux output settles.
- Samples SAIDA once per channel and assembles the four samples into a 4-bit frame with a one-cycle valid pulse.
- Replaces hand-driven selects in benches and gives the mux a real consumer.

Parameters:
DWELL, 2, cycles each channel is held before SAIDA is sampled; legal range 1..255.
QW, 8, width of the frame counter QUADROS.

Ports:
CLK  input  1  system clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
INICIO  input  1  start request; level sampled at rising edge
CONTINUO  input  1  1 = restart a new frame immediately after each completed frame
ABORTAR  input  1  synchronous abort of a frame in progress
SAIDA  input  1  data returned by the 4:1 mux for the currently selected channel
A  output  1  select MSB to mux (channel index bit 1)
B  output  1  select LSB to mux (channel index bit 0)
DADOS  output  4  last completed frame; bit i = sample of channel i (X0→bit0 … X3→bit3)
VALIDO  output  1  one-cycle pulse: DADOS updated this cycle
OCUPADO  output  1  1 while a frame is in progress
QUADROS  output  QW  count of completed frames, wraps

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high on RST.
- Reset values, all registered: A=0, B=0, DADOS=0, VALIDO=0, OCUPADO=0, QUADROS=0. State is IDLE, channel index idx=0, dwell counter cnt=0, shadow register sh[2:0]=0.
- Channel map: {A,B} = idx.
  - 00 → X0
  - 01 → X1
  - 10 → X2
  - 11 → X3
- States: IDLE, SCAN.
- IDLE:
  - A=B=0, OCUPADO=0.
  - At an edge with INICIO=1 (and ABORTAR=0): state←SCAN, idx←0, cnt←0, OCUPADO←1.
- SCAN, per edge:
  - If cnt < DWELL-1: cnt←cnt+1.
  - Else, sample edge:
    - idx<3: sh[idx]←SAIDA, idx←idx+1, cnt←0.
    - idx=3: DADOS←{SAIDA, sh[2:0]}, VALIDO←1, QUADROS←QUADROS+1 (mod 2^QW), cnt←0, idx←0.
      - If CONTINUO=1 at this edge, remain in SCAN.
      - Otherwise state←IDLE, OCUPADO←0.
- Timing:
  - The edge that samples INICIO=1 is E0.
  - Channel k is sampled at edge E0+(k+1)·DWELL.
  - VALIDO is high in the cycle following E0+4·DWELL, i.e. frame latency is 4·DWELL cycles.
  - In continuous mode, frames repeat every 4·DWELL cycles with no gap.
- VALIDO is high for exactly one cycle per completed frame and is 0 in all other cycles.
- DADOS holds its value between frames. It is not modified by abort, by INICIO, or by leaving SCAN.
- INICIO while in SCAN is ignored: no restart, no effect on idx/cnt.
- ABORTAR=1 at any edge in SCAN: next state is IDLE with A=B=0, OCUPADO=0, cnt=idx=0, sh cleared.
  - No VALIDO, and QUADROS is unchanged.
  - This holds even if that edge is the final sample edge, because abort wins.
- ABORTAR in IDLE has no effect. INICIO and ABORTAR together in IDLE: stay IDLE.
- Priority: RST > ABORTAR > frame completion > INICIO.
- RST mid-frame: all outputs return to reset values at that edge, including DADOS=0 and QUADROS=0.
- QUADROS wraps from 2^QW-1 to 0 with no flag.
- A/B change only on edges. SAIDA is assumed combinational from A/B and is captured at the end of the dwell window, never in the cycle a select changes when DWELL≥2.
- With DWELL=1, SAIDA is sampled one cycle after its select is applied; this is legal.
- The counter width is sized to hold DWELL-1.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, INICIO=0 for 10 cycles → A=B=0, DADOS=0, VALIDO=0, OCUPADO=0, QUADROS=0 throughout.
- Single frame, DWELL=2: mux model with X0..X3=1,0,1,1; INICIO pulse at E0 →
  - {A,B} = 00,01,10,11 for 2 cycles each;
  - VALIDO pulse one cycle after E0+8, DADOS=4'b1101, QUADROS=1;
  - then OCUPADO=0 and A=B=0.
- Continuous mode: CONTINUO=1, X pattern changed to 0,1,1,0 after the first frame →
  - VALIDO pulses every 8 cycles;
  - second frame DADOS=4'b0110; QUADROS increments per pulse.
- Abort on final sample edge: ABORTAR=1 exactly at E0+8 → no VALIDO, DADOS keeps its prior value, QUADROS unchanged, OCUPADO=0 next cycle.
- INICIO during SCAN: extra INICIO pulses at E0+3 and E0+5 → frame completes exactly at E0+8, with only one VALIDO.
- Wrap and mid-frame reset: QW=2, CONTINUO=1, run 5 frames → QUADROS goes 1,2,3,0,1; then RST at E+3 of the next frame → all outputs 0 at the following cycle.
